// File: rtl/branch_predict_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | branch_predict_unit: EX-stage branch resolution plus direct-mapped      |
// | 2-bit-counter branch target predictor.          Revision: 1.0           |
// +------------------------------------------------------------------------+
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [6:0]       ex_op,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_zero,
  input  logic             ex_brless,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             br_unsigned,
  output logic [1:0]       pcsel,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [6:0]      c_op_branch = 7'b1100011;
  localparam logic [6:0]      c_op_jal    = 7'b1101111;
  localparam logic [6:0]      c_op_jalr   = 7'b1100111;
  localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic w_is_br;
  logic w_cond;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_taken;
  logic w_mispredict;

  always_comb begin
    w_is_br = 1'b0;
    w_cond  = 1'b0;
    if (ex_op == c_op_branch) begin
      case (ex_funct3)
        3'b000:         begin w_is_br = 1'b1; w_cond = ex_zero;    end
        3'b001:         begin w_is_br = 1'b1; w_cond = ~ex_zero;   end
        3'b100, 3'b110: begin w_is_br = 1'b1; w_cond = ex_brless;  end
        3'b101, 3'b111: begin w_is_br = 1'b1; w_cond = ~ex_brless; end
        default:        begin w_is_br = 1'b0; w_cond = 1'b0;       end
      endcase
    end
  end

  assign w_is_jal    = (ex_op == c_op_jal);
  assign w_is_jalr   = (ex_op == c_op_jalr) && (ex_funct3 == 3'b000);
  assign w_taken     = ex_valid & ((w_is_br & w_cond) | w_is_jal | w_is_jalr);
  assign br_unsigned = w_is_br & (ex_funct3[2:1] == 2'b11);

  // A wrong target on a correctly predicted taken branch still redirects.
  assign w_mispredict = ex_valid &
                        ((w_taken != ex_pred_taken) |
                         (w_taken & ex_pred_taken & (ex_target != ex_pred_target)));

  always_comb begin
    pcsel = 2'b00;
    if (ex_valid & w_is_jalr) begin
      pcsel = 2'b10;
    end else if (w_taken) begin
      pcsel = 2'b01;
    end
  end

  assign flush       = w_mispredict;
  assign redirect_pc = w_taken ? ex_target : (ex_pc + c_pc_step);

  logic [IDX-1:0]   w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX-1:0]   w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_if_hit;
  logic             w_ex_hit;
  logic             w_unused_pc_lsb;

  assign w_if_idx = if_pc[IDX+1:2];
  assign w_if_tag = if_pc[XLEN-1:IDX+2];
  assign w_ex_idx = ex_pc[IDX+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX+2];
  assign w_unused_pc_lsb = ^if_pc[1:0];

  assign w_if_hit    = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
  assign w_ex_hit    = valid_q[w_ex_idx] && (tag_q[w_ex_idx] == w_ex_tag);
  assign pred_taken  = w_if_hit & ctr_q[w_if_idx][1];
  assign pred_target = pred_taken ? target_q[w_if_idx] : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (w_mispredict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign mispredict_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else begin
      cnt_q <= cnt_d;
      if (ex_valid) begin
        if (w_is_br) begin
          if (w_ex_hit) begin
            if (w_cond) begin
              if (ctr_q[w_ex_idx] != 2'b11) ctr_q[w_ex_idx] <= ctr_q[w_ex_idx] + 2'd1;
              target_q[w_ex_idx] <= ex_target;
            end else if (ctr_q[w_ex_idx] != 2'b00) begin
              ctr_q[w_ex_idx] <= ctr_q[w_ex_idx] - 2'd1;
            end
          end else if (w_cond) begin
            valid_q[w_ex_idx]  <= 1'b1;
            tag_q[w_ex_idx]    <= w_ex_tag;
            target_q[w_ex_idx] <= ex_target;
            ctr_q[w_ex_idx]    <= 2'b10;
          end
        end else if (w_is_jal) begin
          valid_q[w_ex_idx]  <= 1'b1;
          tag_q[w_ex_idx]    <= w_ex_tag;
          target_q[w_ex_idx] <= ex_target;
          ctr_q[w_ex_idx]    <= 2'b11;
        end else if (!w_is_jalr && w_ex_hit) begin
          valid_q[w_ex_idx] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_branch_predict_unit: directed bench with a reference model of the    |
// | predictor for a 16-entry and a 4-entry/2-bit-counter instance.          |
// +------------------------------------------------------------------------+
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_zero;
  logic        ex_brless;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        b_pred_taken, s_pred_taken;
  logic [31:0] b_pred_target, s_pred_target;
  logic        b_br_unsigned, s_br_unsigned;
  logic [1:0]  b_pcsel, s_pcsel;
  logic        b_flush, s_flush;
  logic [31:0] b_redirect, s_redirect;
  logic [15:0] b_cnt;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(16)) u_big (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(b_pred_taken), .pred_target(b_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_zero(ex_zero), .ex_brless(ex_brless), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .br_unsigned(b_br_unsigned), .pcsel(b_pcsel), .flush(b_flush),
    .redirect_pc(b_redirect), .mispredict_cnt(b_cnt)
  );

  branch_predict_unit #(.XLEN(32), .ENTRIES(4), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_zero(ex_zero), .ex_brless(ex_brless), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .br_unsigned(s_br_unsigned), .pcsel(s_pcsel), .flush(s_flush),
    .redirect_pc(s_redirect), .mispredict_cnt(s_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each entry remembers the full PC that allocated it.
  bit          mv   [2][16];
  longint      mpc  [2][16];
  logic [31:0] mtgt [2][16];
  int          mctr [2][16];
  int          mcnt [2];
  int          ent  [2] = '{16, 4};
  int          cmax [2] = '{65535, 3};

  // 0 = non-control, 1 = conditional branch, 2 = jal, 3 = jalr
  function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) return 1;
    if (op == 7'h6F) return 2;
    if (op == 7'h67 && f3 == 3'd0) return 3;
    return 0;
  endfunction

  function automatic bit m_taken();
    int kd = kind_of(ex_op, ex_funct3);
    bit c;
    case (ex_funct3)
      3'd0:       c = ex_zero;
      3'd1:       c = !ex_zero;
      3'd4, 3'd6: c = ex_brless;
      default:    c = !ex_brless;
    endcase
    if (!ex_valid) return 1'b0;
    if (kd == 1) return c;
    return kd >= 2;
  endfunction

  function automatic bit m_mispred(input bit at);
    return ex_valid && ((at != ex_pred_taken) ||
                        (at && ex_pred_taken && ex_target != ex_pred_target));
  endfunction

  function automatic bit m_hit(input int k, input longint pc);
    int idx = int'((pc / 4) % ent[k]);
    return mv[k][idx] && (mpc[k][idx] / (4 * ent[k]) == pc / (4 * ent[k]));
  endfunction

  task automatic check_inst(input int k);
    logic        a_pt, a_fl, a_bu;
    logic [31:0] a_tgt, a_red;
    logic [1:0]  a_ps;
    logic [15:0] a_cnt;
    longint      ip;
    int          idx, kd;
    bit          at, ep;
    logic [31:0] et, er, p4;
    logic [1:0]  eps;
    if (k == 0) begin
      a_pt = b_pred_taken; a_tgt = b_pred_target; a_fl = b_flush;
      a_bu = b_br_unsigned; a_ps = b_pcsel; a_red = b_redirect; a_cnt = b_cnt;
    end else begin
      a_pt = s_pred_taken; a_tgt = s_pred_target; a_fl = s_flush;
      a_bu = s_br_unsigned; a_ps = s_pcsel; a_red = s_redirect; a_cnt = {14'd0, s_cnt};
    end
    ip  = if_pc;
    idx = int'((ip / 4) % ent[k]);
    ep  = m_hit(k, ip) && mctr[k][idx] >= 2;
    et  = ep ? mtgt[k][idx] : 32'd0;
    kd  = kind_of(ex_op, ex_funct3);
    at  = m_taken();
    p4  = ex_pc + 32'd4;
    er  = at ? ex_target : p4;
    eps = (ex_valid && kd == 3) ? 2'd2 : (at ? 2'd1 : 2'd0);
    chk($sformatf("k%0d_pred_taken", k), 64'(a_pt), 64'(ep));
    chk($sformatf("k%0d_pred_target", k), 64'(a_tgt), 64'(et));
    chk($sformatf("k%0d_flush", k), 64'(a_fl), 64'(m_mispred(at)));
    chk($sformatf("k%0d_redirect", k), 64'(a_red), 64'(er));
    chk($sformatf("k%0d_pcsel", k), 64'(a_ps), 64'(eps));
    chk($sformatf("k%0d_br_unsigned", k), 64'(a_bu),
        64'(kd == 1 && ex_funct3[2:1] == 2'b11));
    chk($sformatf("k%0d_mispredict_cnt", k), 64'(a_cnt), 64'(mcnt[k]));
  endtask

  // Advance the model by the rising edge that follows this negedge.
  task automatic model_step();
    bit at, mp, hit;
    int kd, idx;
    longint p;
    at = m_taken();
    mp = m_mispred(at);
    kd = kind_of(ex_op, ex_funct3);
    p  = ex_pc;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          mv[k][i] = 1'b0;
          mctr[k][i] = 0;
        end
        mcnt[k] = 0;
      end else begin
        if (mp && mcnt[k] < cmax[k]) mcnt[k]++;
        if (ex_valid) begin
          idx = int'((p / 4) % ent[k]);
          hit = m_hit(k, p);
          if (kd == 1 && hit) begin
            if (at) begin
              if (mctr[k][idx] < 3) mctr[k][idx]++;
              mtgt[k][idx] = ex_target;
            end else if (mctr[k][idx] > 0) begin
              mctr[k][idx]--;
            end
          end else if ((kd == 1 && at) || kd == 2) begin
            mv[k][idx]   = 1'b1;
            mpc[k][idx]  = p;
            mtgt[k][idx] = ex_target;
            mctr[k][idx] = (kd == 2) ? 3 : 2;
          end else if (kd == 0 && hit) begin
            mv[k][idx] = 1'b0;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) check_inst(k);
    end
    model_step();
  end

  task automatic drv(input bit v, input logic [31:0] pc, input logic [6:0] op,
                     input logic [2:0] f3, input bit z, input bit lt,
                     input logic [31:0] tgt, input bit pt, input logic [31:0] ptg);
    ex_valid = v; ex_pc = pc; ex_op = op; ex_funct3 = f3; ex_zero = z;
    ex_brless = lt; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 7'h13, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc; logic [6:0] op; logic [2:0] f3; bit z; bit lt;
    logic [31:0] tgt; bit pt; logic [31:0] ptg;
  } vec_t;

  vec_t vecs [8] = '{
    '{32'h0000_0140, 7'h63, 3'd1, 1'b0, 1'b0, 32'h0000_0180, 1'b0, 32'h0},
    '{32'h0000_0140, 7'h63, 3'd1, 1'b0, 1'b0, 32'h0000_0180, 1'b1, 32'h0000_0184},
    '{32'h0000_0144, 7'h63, 3'd4, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0},
    '{32'h0000_0148, 7'h63, 3'd5, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100},
    '{32'h0000_014C, 7'h63, 3'd7, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 32'h0},
    '{32'h0000_0150, 7'h63, 3'd2, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010},
    '{32'hFFFF_FFFC, 7'h33, 3'd0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0},
    '{32'h0000_0140, 7'h63, 3'd1, 1'b1, 1'b0, 32'h0000_0180, 1'b1, 32'h0000_0180}
  };

  initial begin
    rst = 1'b1;
    if_pc = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    if_pc = 32'h100;
    mid();
    chk("reset_pred_taken", 64'(b_pred_taken), 64'd0);
    chk("reset_pred_target", 64'(b_pred_target), 64'd0);
    chk("reset_cnt", 64'(b_cnt), 64'd0);
    nxt();

    drv(1'b1, 32'h100, 7'h63, 3'd0, 1'b1, 1'b0, 32'h140, 1'b0, 32'h0);
    mid();
    chk("beq_flush", 64'(b_flush), 64'd1);
    chk("beq_pcsel", 64'(b_pcsel), 64'd1);
    chk("beq_redirect", 64'(b_redirect), 64'h140);
    nxt();

    idle();
    mid();
    chk("alloc_pred_taken", 64'(b_pred_taken), 64'd1);
    chk("alloc_pred_target", 64'(b_pred_target), 64'h140);
    chk("alloc_cnt", 64'(b_cnt), 64'd1);
    nxt();

    drv(1'b1, 32'h100, 7'h63, 3'd0, 1'b0, 1'b0, 32'h140, 1'b1, 32'h140);
    mid();
    chk("nt1_flush", 64'(b_flush), 64'd1);
    chk("nt1_redirect", 64'(b_redirect), 64'h104);
    nxt();
    idle();
    mid();
    chk("nt1_pred_taken", 64'(b_pred_taken), 64'd0);
    nxt();
    drv(1'b1, 32'h100, 7'h63, 3'd0, 1'b0, 1'b0, 32'h140, 1'b0, 32'h0);
    mid();
    chk("nt2_flush", 64'(b_flush), 64'd0);
    nxt();

    if_pc = 32'h180;
    drv(1'b1, 32'h180, 7'h67, 3'd0, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0);
    mid();
    chk("jalr_pcsel", 64'(b_pcsel), 64'd2);
    chk("jalr_flush", 64'(b_flush), 64'd1);
    chk("jalr_redirect", 64'(b_redirect), 64'h200);
    nxt();
    idle();
    mid();
    chk("jalr_no_alloc", 64'(b_pred_taken), 64'd0);
    nxt();

    if_pc = 32'h100;
    drv(1'b1, 32'h100, 7'h6F, 3'd0, 1'b0, 1'b0, 32'h300, 1'b0, 32'h0);
    mid();
    chk("same_cycle_no_bypass", 64'(b_pred_taken), 64'd0);
    nxt();
    idle();
    mid();
    chk("jal_pred_taken", 64'(b_pred_taken), 64'd1);
    chk("jal_pred_target", 64'(b_pred_target), 64'h300);
    nxt();

    drv(1'b1, 32'h100, 7'h33, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
    mid();
    chk("nonctl_flush", 64'(b_flush), 64'd1);
    chk("nonctl_redirect", 64'(b_redirect), 64'h104);
    nxt();
    idle();
    mid();
    chk("nonctl_invalidated", 64'(b_pred_taken), 64'd0);
    chk("big_cnt_5", 64'(b_cnt), 64'd5);
    chk("small_cnt_sat", 64'(s_cnt), 64'd3);
    nxt();

    drv(1'b1, 32'h100, 7'h6F, 3'd0, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
    nxt();
    idle();
    if_pc = 32'h110;
    mid();
    chk("alias_no_false_hit", 64'(s_pred_taken), 64'd0);
    nxt();
    if_pc = 32'h100;
    mid();
    chk("alias_true_hit", 64'(s_pred_target), 64'h400);
    nxt();

    drv(1'b1, 32'h120, 7'h63, 3'd6, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    mid();
    chk("bltu_unsigned", 64'(b_br_unsigned), 64'd1);
    chk("bltu_pcsel", 64'(b_pcsel), 64'd1);
    nxt();

    foreach (vecs[i]) begin
      if_pc = vecs[i].pc;
      drv(1'b1, vecs[i].pc, vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].lt,
          vecs[i].tgt, vecs[i].pt, vecs[i].ptg);
      nxt();
    end
    idle();
    nxt();

    rst = 1'b1;
    drv(1'b1, 32'h100, 7'h63, 3'd0, 1'b1, 1'b0, 32'h140, 1'b0, 32'h0);
    mid();
    chk("rst_comb_flush", 64'(b_flush), 64'd1);
    nxt();
    rst = 1'b0;
    idle();
    mid();
    chk("rst_cnt_cleared", 64'(b_cnt), 64'd0);
    chk("rst_table_cleared", 64'(b_pred_taken), 64'd0);
    nxt();

    repeat (2) nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
